// File: rtl/conv_iter_pkg.sv
// Shared types and elaboration helpers for the convolution window iterator.
// Holds the sequencer state encoding and the output-dimension / drain-length math.
package conv_iter_pkg;

    typedef enum logic [2:0] {
        ST_INIT,
        ST_LOAD_W,
        ST_LOAD_B,
        ST_READY,
        ST_SCAN,
        ST_DRAIN,
        ST_DONE
    } state_t;

    function automatic int out_dim(input int i, input int f, input int s);
        return (i - f) / s + 1;
    endfunction

    // Enough cycles for the deepest MAC accumulation plus bias add and write-back.
    function automatic int drain_default(input int f, input int c, input int filt);
        return f * f * c + filt + 3;
    endfunction

    // A port must be at least one bit wide even when there is only one index.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/win_stride_counter2d.sv
// 2-D strided raster counter: x advances by STEP, wrapping into y; o_last flags the final position.
module win_stride_counter2d #(
    parameter int XW   = 5,
    parameter int YW   = 5,
    parameter int NX   = 28,
    parameter int NY   = 28,
    parameter int STEP = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_en,
    input  logic          i_clear,
    input  logic          i_advance,
    output logic [XW-1:0] o_x,
    output logic [YW-1:0] o_y,
    output logic          o_last
);

    localparam logic [XW-1:0] X_LAST = XW'((NX - 1) * STEP);
    localparam logic [YW-1:0] Y_LAST = YW'((NY - 1) * STEP);
    localparam logic [XW-1:0] X_STEP = XW'(STEP);
    localparam logic [YW-1:0] Y_STEP = YW'(STEP);

    logic [XW-1:0] r_x;
    logic [YW-1:0] r_y;
    logic          w_last_x;
    logic          w_last_y;

    assign w_last_x = (r_x == X_LAST);
    assign w_last_y = (r_y == Y_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_x <= '0;
            r_y <= '0;
        end else if (i_en) begin
            if (i_clear) begin
                r_x <= '0;
                r_y <= '0;
            end else if (i_advance) begin
                if (w_last_x) begin
                    r_x <= '0;
                    r_y <= w_last_y ? '0 : r_y + Y_STEP;
                end else begin
                    r_x <= r_x + X_STEP;
                end
            end
        end
    end

    assign o_x    = r_x;
    assign o_y    = r_y;
    assign o_last = w_last_x & w_last_y;

endmodule

// File: rtl/conv_window_iter.sv
// Convolution layer sequencer: one-time weight/bias load addressing, then repeatable
// strided window scans with valid/ready back-pressure, a pipeline drain and a done pulse.
module conv_window_iter
    import conv_iter_pkg::*;
#(
    parameter int F_SIZE  = 5,
    parameter int STRIDE  = 1,
    parameter int I_W     = 32,
    parameter int I_H     = 32,
    parameter int CHANNEL = 1,
    parameter int FILTERS = 6,
    parameter int DRAIN   = drain_default(F_SIZE, CHANNEL, FILTERS)
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 clk_en,
    input  logic                                 start,
    input  logic                                 win_ready,
    output logic [clog2_min1(F_SIZE*F_SIZE)-1:0] w_addr_f,
    output logic [clog2_min1(CHANNEL)-1:0]       w_addr_ic,
    output logic [clog2_min1(FILTERS)-1:0]       w_addr_oc,
    output logic                                 w_we,
    output logic [clog2_min1(FILTERS)-1:0]       b_addr,
    output logic                                 b_we,
    output logic                                 params_ready,
    output logic [clog2_min1(I_W)-1:0]           win_x,
    output logic [clog2_min1(I_H)-1:0]           win_y,
    output logic                                 win_valid,
    output logic                                 busy,
    output logic                                 done
);

    localparam int W_F  = clog2_min1(F_SIZE * F_SIZE);
    localparam int W_IC = clog2_min1(CHANNEL);
    localparam int W_OC = clog2_min1(FILTERS);
    localparam int W_X  = clog2_min1(I_W);
    localparam int W_Y  = clog2_min1(I_H);
    localparam int W_D  = clog2_min1(DRAIN);

    if (F_SIZE > I_W) begin : g_bad_w
        $fatal(1, "conv_window_iter: F_SIZE exceeds I_W");
    end
    if (F_SIZE > I_H) begin : g_bad_h
        $fatal(1, "conv_window_iter: F_SIZE exceeds I_H");
    end
    if (STRIDE < 1) begin : g_bad_s
        $fatal(1, "conv_window_iter: STRIDE must be at least 1");
    end
    if (DRAIN < 1) begin : g_bad_d
        $fatal(1, "conv_window_iter: DRAIN must be at least 1");
    end

    localparam int O_W = out_dim(I_W, F_SIZE, STRIDE);
    localparam int O_H = out_dim(I_H, F_SIZE, STRIDE);

    localparam logic [W_F-1:0]  F_LAST  = W_F'(F_SIZE * F_SIZE - 1);
    localparam logic [W_IC-1:0] IC_LAST = W_IC'(CHANNEL - 1);
    localparam logic [W_OC-1:0] OC_LAST = W_OC'(FILTERS - 1);
    localparam logic [W_D-1:0]  D_LAST  = W_D'(DRAIN - 1);

    state_t          r_state;
    logic [W_F-1:0]  r_f;
    logic [W_IC-1:0] r_ic;
    logic [W_OC-1:0] r_oc;
    logic            r_w_we;
    logic [W_OC-1:0] r_b_addr;
    logic            r_b_we;
    logic            r_params_ready;
    logic            r_win_valid;
    logic            r_busy;
    logic            r_done;
    logic [W_D-1:0]  r_drain;

    logic            w_clear;
    logic            w_advance;
    logic            w_last_win;
    logic [W_X-1:0]  w_x;
    logic [W_Y-1:0]  w_y;

    // win_valid is always high in SCAN, so ready alone marks a handshake there.
    assign w_clear   = (r_state == ST_READY) && start;
    assign w_advance = (r_state == ST_SCAN) && win_ready;

    win_stride_counter2d #(
        .XW   (W_X),
        .YW   (W_Y),
        .NX   (O_W),
        .NY   (O_H),
        .STEP (STRIDE)
    ) u_scan (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_en      (clk_en),
        .i_clear   (w_clear),
        .i_advance (w_advance),
        .o_x       (w_x),
        .o_y       (w_y),
        .o_last    (w_last_win)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= ST_INIT;
            r_f            <= '0;
            r_ic           <= '0;
            r_oc           <= '0;
            r_w_we         <= 1'b0;
            r_b_addr       <= '0;
            r_b_we         <= 1'b0;
            r_params_ready <= 1'b0;
            r_win_valid    <= 1'b0;
            r_busy         <= 1'b0;
            r_done         <= 1'b0;
            r_drain        <= '0;
        end else if (clk_en) begin
            case (r_state)
                ST_INIT: begin
                    r_state <= ST_LOAD_W;
                    r_w_we  <= 1'b1;
                    r_f     <= '0;
                    r_ic    <= '0;
                    r_oc    <= '0;
                end
                // Output channel fastest, then input channel, then filter tap.
                ST_LOAD_W: begin
                    if (r_oc == OC_LAST) begin
                        r_oc <= '0;
                        if (r_ic == IC_LAST) begin
                            r_ic <= '0;
                            if (r_f == F_LAST) begin
                                r_state  <= ST_LOAD_B;
                                r_w_we   <= 1'b0;
                                r_b_we   <= 1'b1;
                                r_b_addr <= '0;
                            end else begin
                                r_f <= r_f + 1'b1;
                            end
                        end else begin
                            r_ic <= r_ic + 1'b1;
                        end
                    end else begin
                        r_oc <= r_oc + 1'b1;
                    end
                end
                ST_LOAD_B: begin
                    if (r_b_addr == OC_LAST) begin
                        r_state        <= ST_READY;
                        r_b_we         <= 1'b0;
                        r_params_ready <= 1'b1;
                    end else begin
                        r_b_addr <= r_b_addr + 1'b1;
                    end
                end
                ST_READY: begin
                    if (start) begin
                        r_state     <= ST_SCAN;
                        r_win_valid <= 1'b1;
                        r_busy      <= 1'b1;
                    end
                end
                ST_SCAN: begin
                    if (win_ready && w_last_win) begin
                        r_state     <= ST_DRAIN;
                        r_win_valid <= 1'b0;
                        r_drain     <= '0;
                    end
                end
                ST_DRAIN: begin
                    if (r_drain == D_LAST) begin
                        r_state <= ST_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else begin
                        r_drain <= r_drain + 1'b1;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_READY;
                    r_done  <= 1'b0;
                end
                default: r_state <= ST_INIT;
            endcase
        end
    end

    assign w_addr_f     = r_f;
    assign w_addr_ic    = r_ic;
    assign w_addr_oc    = r_oc;
    assign w_we         = r_w_we;
    assign b_addr       = r_b_addr;
    assign b_we         = r_b_we;
    assign params_ready = r_params_ready;
    assign win_x        = w_x;
    assign win_y        = w_y;
    assign win_valid    = r_win_valid;
    assign busy         = r_busy;
    assign done         = r_done;

endmodule

// File: tb/tb_conv_window_iter.sv
// Bench for conv_window_iter: default and small rectangular/strided instances driven side by side
// and compared against an arithmetic model of the load order, raster scan, drain and done timing.
module tb_conv_window_iter;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic clk_en = 1'b0;
    logic start_a = 1'b0, rdy_a = 1'b0, start_b = 1'b0, rdy_b = 1'b0;

    always #5 clk = ~clk;

    logic [4:0] wf_a;  logic [0:0] wic_a; logic [2:0] woc_a; logic [2:0] ba_a;
    logic [4:0] x_a;   logic [4:0] y_a;
    logic wwe_a, bwe_a, pr_a, v_a, busy_a, done_a;

    logic [3:0] wf_b;  logic [0:0] wic_b; logic [0:0] woc_b; logic [0:0] ba_b;
    logic [2:0] x_b;   logic [2:0] y_b;
    logic wwe_b, bwe_b, pr_b, v_b, busy_b, done_b;

    conv_window_iter dut_a (
        .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .start(start_a), .win_ready(rdy_a),
        .w_addr_f(wf_a), .w_addr_ic(wic_a), .w_addr_oc(woc_a), .w_we(wwe_a),
        .b_addr(ba_a), .b_we(bwe_a), .params_ready(pr_a),
        .win_x(x_a), .win_y(y_a), .win_valid(v_a), .busy(busy_a), .done(done_a)
    );

    conv_window_iter #(
        .F_SIZE(3), .STRIDE(2), .I_W(8), .I_H(6), .CHANNEL(2), .FILTERS(2)
    ) dut_b (
        .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .start(start_b), .win_ready(rdy_b),
        .w_addr_f(wf_b), .w_addr_ic(wic_b), .w_addr_oc(woc_b), .w_we(wwe_b),
        .b_addr(ba_b), .b_we(bwe_b), .params_ready(pr_b),
        .win_x(x_b), .win_y(y_b), .win_valid(v_b), .busy(busy_b), .done(done_b)
    );

    // Per-instance configuration: filter, channels, filters, width, height, stride.
    int cf_f[2] = '{5, 3};
    int cf_c[2] = '{1, 2};
    int cf_n[2] = '{6, 2};
    int cf_w[2] = '{32, 8};
    int cf_h[2] = '{32, 6};
    int cf_s[2] = '{1, 2};

    int n_chk = 0;
    int n_fail = 0;

    typedef struct {
        int wf, wic, woc, wwe, ba, bwe, pr, x, y, v, busy, done;
    } obs_t;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic obs_t get_obs(input int sel);
        obs_t o;
        if (sel == 0) begin
            o.wf = int'(wf_a); o.wic = int'(wic_a); o.woc = int'(woc_a); o.wwe = int'(wwe_a);
            o.ba = int'(ba_a); o.bwe = int'(bwe_a); o.pr = int'(pr_a);
            o.x = int'(x_a); o.y = int'(y_a); o.v = int'(v_a); o.busy = int'(busy_a); o.done = int'(done_a);
        end else begin
            o.wf = int'(wf_b); o.wic = int'(wic_b); o.woc = int'(woc_b); o.wwe = int'(wwe_b);
            o.ba = int'(ba_b); o.bwe = int'(bwe_b); o.pr = int'(pr_b);
            o.x = int'(x_b); o.y = int'(y_b); o.v = int'(v_b); o.busy = int'(busy_b); o.done = int'(done_b);
        end
        return o;
    endfunction

    function automatic int drain_of(input int s);
        return cf_f[s] * cf_f[s] * cf_c[s] + cf_n[s] + 3;
    endfunction

    task automatic chk_zero(input int s, input string tag);
        obs_t o;
        o = get_obs(s);
        chk($sformatf("%s_wf%0d", tag, s), o.wf, 0);
        chk($sformatf("%s_wic%0d", tag, s), o.wic, 0);
        chk($sformatf("%s_woc%0d", tag, s), o.woc, 0);
        chk($sformatf("%s_wwe%0d", tag, s), o.wwe, 0);
        chk($sformatf("%s_ba%0d", tag, s), o.ba, 0);
        chk($sformatf("%s_bwe%0d", tag, s), o.bwe, 0);
        chk($sformatf("%s_pr%0d", tag, s), o.pr, 0);
        chk($sformatf("%s_x%0d", tag, s), o.x, 0);
        chk($sformatf("%s_y%0d", tag, s), o.y, 0);
        chk($sformatf("%s_v%0d", tag, s), o.v, 0);
        chk($sformatf("%s_busy%0d", tag, s), o.busy, 0);
        chk($sformatf("%s_done%0d", tag, s), o.done, 0);
    endtask

    // Called right after reset release; k counts enabled edges since then.
    task automatic load_check(input int kmax);
        obs_t o;
        int nw, c, fn;
        for (int k = 0; k <= kmax; k++) begin
            if (k > 0) begin
                @(posedge clk);
                #1;
            end
            for (int s = 0; s < 2; s++) begin
                if (k == 0) begin
                    chk_zero(s, "post_rst");
                end else begin
                    o  = get_obs(s);
                    fn = cf_n[s];
                    nw = cf_f[s] * cf_f[s] * cf_c[s] * fn;
                    chk($sformatf("w_we%0d@%0d", s, k), o.wwe, int'(k <= nw));
                    if (k <= nw) begin
                        c = k - 1;
                        chk($sformatf("w_oc%0d@%0d", s, k), o.woc, c % fn);
                        chk($sformatf("w_ic%0d@%0d", s, k), o.wic, (c / fn) % cf_c[s]);
                        chk($sformatf("w_f%0d@%0d", s, k), o.wf, c / (fn * cf_c[s]));
                    end
                    chk($sformatf("b_we%0d@%0d", s, k), o.bwe, int'(k > nw && k <= nw + fn));
                    if (k > nw && k <= nw + fn)
                        chk($sformatf("b_addr%0d@%0d", s, k), o.ba, k - nw - 1);
                    chk($sformatf("pr%0d@%0d", s, k), o.pr, int'(k >= 1 + nw + fn));
                    chk($sformatf("v%0d@%0d", s, k), o.v, 0);
                end
            end
        end
    endtask

    task automatic drive(input int sel, input logic st, input logic r);
        if (sel == 0) begin start_a = st; rdy_a = r; end
        else begin start_b = st; rdy_b = r; end
    endtask

    // ph: 0 READY, 1 SCAN, 2 DRAIN, 3 DONE
    task automatic check_state(input int sel, input int ph, input int idx, input int cyc);
        obs_t o;
        int ow, s;
        o  = get_obs(sel);
        ow = (cf_w[sel] - cf_f[sel]) / cf_s[sel] + 1;
        s  = cf_s[sel];
        chk($sformatf("valid%0d@%0d", sel, cyc), o.v, int'(ph == 1));
        chk($sformatf("busy%0d@%0d", sel, cyc), o.busy, int'(ph == 1 || ph == 2));
        chk($sformatf("done%0d@%0d", sel, cyc), o.done, int'(ph == 3));
        chk($sformatf("pr_hold%0d@%0d", sel, cyc), o.pr, 1);
        chk($sformatf("no_reload%0d@%0d", sel, cyc), o.wwe | o.bwe, 0);
        if (ph == 1) begin
            chk($sformatf("x%0d@%0d", sel, cyc), o.x, (idx % ow) * s);
            chk($sformatf("y%0d@%0d", sel, cyc), o.y, (idx / ow) * s);
        end
    endtask

    task automatic run_frame(input int sel, input int p_rdy, input int p_en, input bit noise);
        obs_t prv, cur;
        int ph, idx, d, en_cnt, stall, guard, total, drn;
        logic en, r, st;
        total = ((cf_w[sel] - cf_f[sel]) / cf_s[sel] + 1) * ((cf_h[sel] - cf_f[sel]) / cf_s[sel] + 1);
        drn   = drain_of(sel);
        @(negedge clk);
        clk_en = 1'b1;
        drive(sel, 1'b1, 1'b0);
        @(posedge clk);
        #1;
        drive(sel, 1'b0, 1'b0);
        ph = 1; idx = 0; d = 0; en_cnt = 0; stall = 0; guard = 0;
        check_state(sel, ph, idx, en_cnt);
        prv = get_obs(sel);
        while (ph != 0 && guard < 20000) begin
            guard++;
            @(negedge clk);
            en = ($urandom_range(99) < p_en);
            r  = ($urandom_range(99) < p_rdy);
            st = noise ? ((ph == 3) ? 1'b1 : 1'($urandom_range(1))) : 1'b0;
            clk_en = en;
            drive(sel, st, r);
            @(posedge clk);
            #1;
            cur = get_obs(sel);
            if (en) begin
                en_cnt++;
                case (ph)
                    1: if (r) begin
                           if (idx == total - 1) begin ph = 2; d = 0; end
                           else idx++;
                       end else stall++;
                    2: if (d == drn - 1) ph = 3; else d++;
                    3: ph = 0;
                    default: ;
                endcase
                check_state(sel, ph, idx, en_cnt);
                if (ph == 3)
                    chk($sformatf("done_cycle%0d", sel), en_cnt, total + drn + stall);
            end else begin
                chk($sformatf("stall_x%0d", sel), cur.x, prv.x);
                chk($sformatf("stall_y%0d", sel), cur.y, prv.y);
                chk($sformatf("stall_v%0d", sel), cur.v, prv.v);
                chk($sformatf("stall_busy%0d", sel), cur.busy, prv.busy);
                chk($sformatf("stall_done%0d", sel), cur.done, prv.done);
            end
            prv = cur;
        end
        if (guard >= 20000) chk($sformatf("frame_timeout%0d", sel), ph, 0);
        drive(sel, 1'b0, 1'b0);
        clk_en = 1'b1;
        @(posedge clk);
        #1;
        check_state(sel, 0, 0, -1);
    endtask

    initial begin
        obs_t o;
        rst_n  = 1'b0;
        clk_en = 1'b1;
        repeat (3) @(negedge clk);
        chk_zero(0, "rst");
        chk_zero(1, "rst");
        rst_n = 1'b1;
        load_check(160);

        run_frame(0, 100, 100, 1'b0);
        run_frame(1, 100, 100, 1'b0);
        run_frame(0, 50, 80, 1'b1);
        run_frame(1, 50, 80, 1'b1);
        run_frame(0, 100, 100, 1'b1);

        // Reset in the middle of a scan, at window 100 = (16,3).
        @(negedge clk);
        clk_en  = 1'b1;
        start_a = 1'b1;
        rdy_a   = 1'b1;
        @(posedge clk);
        #1;
        start_a = 1'b0;
        repeat (100) @(posedge clk);
        #1;
        o = get_obs(0);
        chk("mid_x", o.x, 16);
        chk("mid_y", o.y, 3);
        chk("mid_v", o.v, 1);
        #1;
        rst_n = 1'b0;
        #1;
        chk_zero(0, "async_rst");
        chk_zero(1, "async_rst");
        rdy_a = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        load_check(160);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
